// File: rtl/cm811_init_pkg.sv
// Shared types and constants for the CM811 board-initialisation sequencer.
package cm811_init_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_ERR     = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
  localparam logic [1:0] FAIL_ABORT   = 2'b11;

endpackage

// File: rtl/cm811_init_timer.sv
// Per-attempt timeout counter: cleared on issue, counts while waiting, saturates.
module cm811_init_timer #(
  parameter int unsigned     TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(10_000_000)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] TermCnt = TIMEOUT_CYC - TO_W'(1);

  logic [TO_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout value disables expiry entirely.
  assign expired_o = (TIMEOUT_CYC != '0) && (cnt_q == TermCnt);

endmodule

// File: rtl/cm811_init_seq.sv
// CM811 init sequencer: runs stages in order with per-stage timeout, bounded
// retry, abort, and latched failure diagnostics.
module cm811_init_seq
  import cm811_init_pkg::*;
#(
  parameter int unsigned     NUM_STAGES  = 4,
  parameter int unsigned     STG_W       = 4,
  parameter int unsigned     TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(10_000_000),
  parameter int unsigned     MAX_RETRY   = 2
) (
  input  logic                  sys_clk,
  input  logic                  glbl_rst_n,
  input  logic                  init_start,
  input  logic                  init_abort,
  output logic                  init_busy,
  output logic                  init_ok,
  output logic                  init_fail,
  output logic [STG_W-1:0]      fail_stage,
  output logic [1:0]            fail_code,
  output logic [NUM_STAGES-1:0] stage_en,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_error,
  output logic [1:0]            retry_cnt
);

  localparam logic [STG_W-1:0] LastIdx  = STG_W'(NUM_STAGES - 1);
  localparam logic [1:0]       MaxRetry = 2'(MAX_RETRY);

  state_e                state_d, state_q;
  logic [STG_W-1:0]      idx_d, idx_q;
  logic [STG_W-1:0]      fail_stage_d, fail_stage_q;
  logic [1:0]            fail_code_d, fail_code_q;
  logic [1:0]            retry_d, retry_q;
  logic                  busy_d, busy_q;
  logic                  ok_d, ok_q;
  logic                  fail_d, fail_q;
  logic [NUM_STAGES-1:0] en_d, en_q;
  logic                  done_sel, err_sel;
  logic                  tmr_clr, tmr_en, tmr_expired;

  cm811_init_timer #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i     (sys_clk),
    .rst_ni    (glbl_rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Only the current stage's handshake bits are observed.
  always_comb begin
    done_sel = 1'b0;
    err_sel  = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == STG_W'(i)) begin
        done_sel = stage_done[i];
        err_sel  = stage_error[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    fail_stage_d = fail_stage_q;
    fail_code_d  = fail_code_q;
    busy_d       = busy_q;
    ok_d         = 1'b0;
    fail_d       = 1'b0;
    en_d         = '0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    if (init_abort && (state_q != StIdle)) begin
      fail_stage_d = idx_q;
      fail_code_d  = FAIL_ABORT;
      fail_d       = 1'b1;
      busy_d       = 1'b0;
      state_d      = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          // The ok/fail pulse cycle still counts as busy, so start waits it out.
          if (init_start && !ok_q && !fail_q) begin
            idx_d        = '0;
            retry_d      = '0;
            fail_stage_d = '0;
            fail_code_d  = FAIL_NONE;
            busy_d       = 1'b1;
            state_d      = StIssue;
          end
        end
        StIssue: begin
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            en_d[i] = (idx_q == STG_W'(i));
          end
          tmr_clr = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          tmr_en = 1'b1;
          if (done_sel) begin
            if (idx_q == LastIdx) begin
              ok_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + STG_W'(1);
              retry_d = '0;
              state_d = StIssue;
            end
          end else if (err_sel || tmr_expired) begin
            if (retry_q < MaxRetry) begin
              retry_d = retry_q + 2'd1;
              state_d = StGap;
            end else begin
              fail_stage_d = idx_q;
              fail_code_d  = err_sel ? FAIL_ERR : FAIL_TIMEOUT;
              fail_d       = 1'b1;
              busy_d       = 1'b0;
              state_d      = StIdle;
            end
          end
        end
        StGap: begin
          state_d = StIssue;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      retry_q      <= '0;
      fail_stage_q <= '0;
      fail_code_q  <= FAIL_NONE;
      busy_q       <= 1'b0;
      ok_q         <= 1'b0;
      fail_q       <= 1'b0;
      en_q         <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      fail_stage_q <= fail_stage_d;
      fail_code_q  <= fail_code_d;
      busy_q       <= busy_d;
      ok_q         <= ok_d;
      fail_q       <= fail_d;
      en_q         <= en_d;
    end
  end

  // Busy stays visible through the terminating pulse cycle.
  assign init_busy  = busy_q | ok_q | fail_q;
  assign init_ok    = ok_q;
  assign init_fail  = fail_q;
  assign fail_stage = fail_stage_q;
  assign fail_code  = fail_code_q;
  assign stage_en   = en_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_cm811_init_seq.sv
// Self-checking bench for cm811_init_seq: timeline model built from per-attempt
// response plans, a hand-derived vector table, randomized plans and reset corners.
module tb_cm811_init_seq;

  localparam int NS   = 4;
  localparam int NR   = 3;
  localparam int TO   = 100;
  localparam int MAXT = 1500;
  localparam int NTBL = 8;

  localparam logic [1:0] KDone = 2'd0;
  localparam logic [1:0] KErr  = 2'd1;
  localparam logic [1:0] KSil  = 2'd2;
  localparam logic [1:0] KBoth = 2'd3;

  typedef struct packed {
    logic [NS-1:0][NR-1:0][1:0] kind;
    logic [NS-1:0][NR-1:0][3:0] dly;
    logic                       ab_en;
    logic [3:0]                 ab_s;
    logic [1:0]                 ab_a;
    logic signed [7:0]          ab_off;
    logic                       noise;
  } plan_t;

  typedef struct packed {
    plan_t      p;
    logic       exp_ok;
    logic [3:0] exp_stage;
    logic [1:0] exp_code;
    logic [1:0] exp_retry;
    int         exp_end;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_start, init_abort;
  logic          init_busy, init_ok, init_fail;
  logic [3:0]    fail_stage;
  logic [1:0]    fail_code;
  logic [NS-1:0] stage_en, stage_done, stage_error;
  logic [1:0]    retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NS-1:0] exp_en [MAXT];
  logic          exp_ok [MAXT];
  logic          exp_fl [MAXT];
  logic          exp_bz [MAXT];
  logic [1:0]    exp_rt [MAXT];
  logic [3:0]    exp_fs [MAXT];
  logic [1:0]    exp_fc [MAXT];
  logic [NS-1:0] st_dn  [MAXT];
  logic [NS-1:0] st_er  [MAXT];
  logic          st_ab  [MAXT];
  logic          st_st  [MAXT];
  int            cur    [MAXT];

  int         m_end;
  logic       m_ok;
  logic [3:0] m_stage;
  logic [1:0] m_code, m_retry;

  int         obs_end;
  logic       obs_ok;
  logic [3:0] obs_stage;
  logic [1:0] obs_code, obs_retry;

  vec_t tbl [NTBL];

  cm811_init_seq #(
    .NUM_STAGES  (NS),
    .STG_W       (4),
    .TO_W        (24),
    .TIMEOUT_CYC (24'd100),
    .MAX_RETRY   (2)
  ) dut (
    .sys_clk     (clk),
    .glbl_rst_n  (rst_n),
    .init_start  (init_start),
    .init_abort  (init_abort),
    .init_busy   (init_busy),
    .init_ok     (init_ok),
    .init_fail   (init_fail),
    .fail_stage  (fail_stage),
    .fail_code   (fail_code),
    .stage_en    (stage_en),
    .stage_done  (stage_done),
    .stage_error (stage_error),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {stage_en, init_ok, init_fail, init_busy, retry_cnt, fail_stage, fail_code};
  endfunction

  function automatic plan_t all_done(input int d);
    plan_t p;
    p = '0;
    for (int s = 0; s < NS; s++) begin
      for (int a = 0; a < NR; a++) begin
        p.kind[s][a] = KDone;
        p.dly[s][a]  = 4'(d);
      end
    end
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int    r, lo;
    p = all_done(0);
    for (int s = 0; s < NS; s++) begin
      for (int a = 0; a < NR; a++) begin
        r = int'($urandom_range(99));
        p.kind[s][a] = (r < 55) ? KDone : (r < 80) ? KErr : (r < 85) ? KSil : KBoth;
        p.dly[s][a]  = 4'($urandom_range(12));
      end
    end
    p.noise = 1'($urandom_range(1));
    if ($urandom_range(3) == 0) begin
      p.ab_en  = 1'b1;
      p.ab_s   = 4'($urandom_range(NS - 1));
      p.ab_a   = 2'($urandom_range(NR - 1));
      lo       = (p.ab_a == 0) ? -1 : -2;
      p.ab_off = 8'(lo + int'($urandom_range(int'(p.dly[p.ab_s][p.ab_a]) - lo)));
    end
    return p;
  endfunction

  // Timeline model: stage_en of an attempt appears at cycle t; a response d
  // cycles later either advances (next enable at +d+2), retries after a gap
  // (+d+3), or ends the run one cycle after the deciding cycle.
  task automatic build(input plan_t p);
    int            t, te, d, ta, ws;
    logic          fin;
    logic [1:0]    k;
    logic [NS-1:0] oh;
    for (int i = 0; i < MAXT; i++) begin
      exp_en[i] = '0; exp_ok[i] = 1'b0; exp_fl[i] = 1'b0; exp_bz[i] = 1'b0;
      exp_rt[i] = '0; exp_fs[i] = '0;   exp_fc[i] = '0;
      st_dn[i]  = '0; st_er[i]  = '0;   st_ab[i]  = 1'b0; st_st[i] = 1'b0; cur[i] = 0;
    end
    t = 2; te = 0; fin = 1'b0;
    m_ok = 1'b0; m_stage = '0; m_code = '0; m_retry = '0;
    for (int s = 0; s < NS && !fin; s++) begin
      oh = NS'(1) << s;
      for (int a = 0; a < NR; a++) begin
        ws = (a == 0) ? t - 1 : t - 2;
        for (int i = ws; i < MAXT; i++) begin
          exp_rt[i] = 2'(a);
          cur[i]    = s;
        end
        m_retry = 2'(a);
        k = p.kind[s][a];
        d = int'(p.dly[s][a]);
        if (p.ab_en && (int'(p.ab_s) == s) && (int'(p.ab_a) == a)) begin
          ta = t + int'(p.ab_off);
          if (ta >= t) exp_en[t] = oh;
          if ((k != KSil) && (d == ta - t)) begin
            if (k == KErr) st_er[ta] |= oh;
            else st_dn[ta] |= oh;
            if (k == KBoth) st_er[ta] |= oh;
          end
          st_ab[ta] = 1'b1;
          te = ta + 1; m_stage = 4'(s); m_code = 2'd3; fin = 1'b1;
          break;
        end
        exp_en[t] = oh;
        if ((k == KDone) || (k == KBoth)) begin
          st_dn[t+d] |= oh;
          if (k == KBoth) st_er[t+d] |= oh;
          if (s == NS - 1) begin
            te = t + d + 1; m_ok = 1'b1; fin = 1'b1;
          end else begin
            t = t + d + 2;
          end
          break;
        end else if (k == KErr) begin
          st_er[t+d] |= oh;
          if (a == NR - 1) begin
            te = t + d + 1; m_stage = 4'(s); m_code = 2'd1; fin = 1'b1;
            break;
          end
          t = t + d + 3;
        end else begin
          if (a == NR - 1) begin
            te = t + TO; m_stage = 4'(s); m_code = 2'd2; fin = 1'b1;
            break;
          end
          t = t + TO + 2;
        end
      end
    end
    m_end = te;
    for (int i = 1; i <= te; i++) exp_bz[i] = 1'b1;
    if (m_ok) begin
      exp_ok[te] = 1'b1;
    end else begin
      exp_fl[te] = 1'b1;
      for (int i = te; i < MAXT; i++) begin
        exp_fs[i] = m_stage;
        exp_fc[i] = m_code;
      end
    end
    if (p.noise) begin
      // Stray pulses on other stages, starts while busy, abort while idle.
      for (int i = 1; i <= te; i++) begin
        st_dn[i] |= NS'($urandom) & ~(NS'(1) << cur[i]);
        st_er[i] |= NS'($urandom) & ~(NS'(1) << cur[i]);
        if ($urandom_range(4) == 0) st_st[i] = 1'b1;
      end
      if (cur[3] != NS - 1) st_dn[3][NS-1] = 1'b1;
      st_ab[te+1] = 1'b1;
    end
  endtask

  task automatic run_plan(input plan_t p, input int stop);
    int last;
    build(p);
    last = (stop >= 0) ? stop : m_end + 2;
    obs_end = -1; obs_ok = 1'b0; obs_stage = '0; obs_code = '0; obs_retry = '0;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      init_start  = (t == 0) || st_st[t];
      init_abort  = st_ab[t];
      stage_done  = st_dn[t];
      stage_error = st_er[t];
      @(negedge clk);
      if (t >= 1) begin
        chk("cycle", t, 32'(dut_vec()),
            32'({exp_en[t], exp_ok[t], exp_fl[t], exp_bz[t], exp_rt[t], exp_fs[t], exp_fc[t]}));
      end
      if ((obs_end < 0) && (init_ok || init_fail)) begin
        obs_end = t; obs_ok = init_ok; obs_stage = fail_stage;
        obs_code = fail_code; obs_retry = retry_cnt;
      end
    end
    init_start = 1'b0; init_abort = 1'b0; stage_done = '0; stage_error = '0;
  endtask

  task automatic chk_result(input string nm, input logic e_ok, input logic [3:0] e_stage,
                            input logic [1:0] e_code, input logic [1:0] e_retry,
                            input int e_end);
    chk({nm, "_end"},   obs_end, 32'(obs_end),   32'(e_end));
    chk({nm, "_ok"},    obs_end, 32'(obs_ok),    32'(e_ok));
    chk({nm, "_stage"}, obs_end, 32'(obs_stage), 32'(e_stage));
    chk({nm, "_code"},  obs_end, 32'(obs_code),  32'(e_code));
    chk({nm, "_retry"}, obs_end, 32'(obs_retry), 32'(e_retry));
  endtask

  initial begin
    rst_n = 1'b0;
    init_start = 1'b0; init_abort = 1'b0; stage_done = '0; stage_error = '0;

    // {plan, ok, fail_stage, fail_code, retry_cnt, pulse cycle}
    tbl[0] = '{all_done(5), 1'b1, 4'd0, 2'd0, 2'd0, 29};
    tbl[1] = '{all_done(5), 1'b0, 4'd2, 2'd1, 2'd2, 38};
    for (int a = 0; a < NR; a++) tbl[1].p.kind[2][a] = KErr;
    tbl[2] = '{all_done(5), 1'b0, 4'd1, 2'd2, 2'd2, 313};
    for (int a = 0; a < NR; a++) tbl[2].p.kind[1][a] = KSil;
    tbl[3] = '{all_done(0), 1'b1, 4'd0, 2'd0, 2'd0, 12};
    tbl[3].p.kind[0][0] = KBoth; tbl[3].p.dly[0][0] = 4'd3; tbl[3].p.noise = 1'b1;
    tbl[4] = '{all_done(5), 1'b0, 4'd1, 2'd3, 2'd0, 15};
    tbl[4].p.ab_en = 1'b1; tbl[4].p.ab_s = 4'd1; tbl[4].p.ab_a = 2'd0; tbl[4].p.ab_off = 8'sd5;
    tbl[5] = '{all_done(0), 1'b1, 4'd0, 2'd0, 2'd0, 15};
    tbl[5].p.kind[0][0] = KErr; tbl[5].p.dly[0][0] = 4'd2; tbl[5].p.dly[0][1] = 4'd1;
    tbl[6] = '{all_done(0), 1'b0, 4'd0, 2'd3, 2'd1, 4};
    tbl[6].p.kind[0][0] = KErr;
    tbl[6].p.ab_en = 1'b1; tbl[6].p.ab_s = 4'd0; tbl[6].p.ab_a = 2'd1; tbl[6].p.ab_off = -8'sd2;
    tbl[7] = '{all_done(0), 1'b0, 4'd0, 2'd3, 2'd0, 2};
    tbl[7].p.ab_en = 1'b1; tbl[7].p.ab_s = 4'd0; tbl[7].p.ab_a = 2'd0; tbl[7].p.ab_off = -8'sd1;

    repeat (3) @(negedge clk);
    chk("reset_state", 0, 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NTBL; i++) begin
      run_plan(tbl[i].p, -1);
      chk_result($sformatf("tbl%0d", i), tbl[i].exp_ok, tbl[i].exp_stage, tbl[i].exp_code,
                 tbl[i].exp_retry, tbl[i].exp_end);
    end

    // Asynchronous reset in the WAIT of stage 2, then a clean restart.
    run_plan(tbl[1].p, -1);
    run_plan(tbl[0].p, 17);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 17, 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_plan(tbl[0].p, -1);
    chk_result("restart", 1'b1, 4'd0, 2'd0, 2'd0, 29);

    for (int i = 0; i < 30; i++) begin
      plan_t p;
      p = rand_plan();
      run_plan(p, -1);
      chk_result($sformatf("rnd%0d", i), m_ok, m_stage, m_code, m_retry, m_end);
    end

    // Abort while idle must leave the latched diagnostics untouched.
    run_plan(tbl[4].p, -1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 init_abort = 1'b1;
      @(negedge clk);
      chk("idle_abort", i, 32'(dut_vec()), 32'({4'd0, 3'b000, 2'd0, 4'd1, 2'd3}));
    end
    init_abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cm811_init_seq.md
Name: cm811_init_seq

Overview:
Parametrised board-initialisation sequencer and next generation of the CM811 init FSM. It runs NUM_STAGES init steps in fixed order (stage 0 first): check RAM, load RAM, compare CRC, read ID, plus extra stages as needed. Each stage gets a one-cycle enable pulse and a done/error handshake. New over the previous generation: per-stage timeout, bounded retry, abort input, and a latched fail stage/cause for diagnostics. Sits between the board bring-up controller (init_start) and the per-stage worker blocks.

Parameters:
NUM_STAGES, 4, number of sequenced stages (1..16)
STG_W, 4, width of stage index (>= clog2(NUM_STAGES), min 1)
TO_W, 24, width of timeout counter
TIMEOUT_CYC, 24'd10_000_000, cycles allowed per attempt before timeout (0 = timeout disabled)
MAX_RETRY, 2, re-attempts allowed per stage after a failed attempt (0..3)

Ports:
sys_clk  in  1  system clock, all logic rising-edge
glbl_rst_n  in  1  asynchronous active-low reset
init_start  in  1  start request, sampled only in IDLE
init_abort  in  1  abort request, honoured in ISSUE/WAIT/GAP
init_busy  out  1  high from cycle after accepted start until ok/fail pulse cycle inclusive
init_ok  out  1  one-cycle pulse: all stages done
init_fail  out  1  one-cycle pulse: sequence failed
fail_stage  out  STG_W  index of failing stage, held until next accepted start
fail_code  out  2  00 none, 01 stage error, 10 timeout, 11 abort; held like fail_stage
stage_en  out  NUM_STAGES  one-hot one-cycle enable pulse to current stage
stage_done  in  NUM_STAGES  per-stage completion pulse
stage_error  in  NUM_STAGES  per-stage error pulse
retry_cnt  out  2  retries used on current stage, for status register

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, stage index 0, timeout counter 0.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: on init_start go to ISSUE. Same edge: idx<=0, retry_cnt<=0, fail_stage<=0, fail_code<=00, init_busy<=1.
- ISSUE: stage_en[idx]<=1 for exactly one cycle, timeout counter<=0, go to WAIT. Latency start->stage_en[0] = 2 cycles.
- WAIT: only stage_done[idx] and stage_error[idx] are observed. Other bits are ignored. Counter increments each cycle.
- Success: stage_done[idx] wins over stage_error[idx] and timeout in the same cycle.
  - If idx==NUM_STAGES-1: init_ok pulse, init_busy<=0, go to IDLE.
  - Else: idx<=idx+1, retry_cnt<=0, go to ISSUE. No idle cycle between stages.
- Failed attempt: stage_error[idx], or counter==TIMEOUT_CYC-1 with TIMEOUT_CYC!=0.
  - Error takes precedence over timeout for fail_code.
  - If retry_cnt<MAX_RETRY: retry_cnt+1, go to GAP.
  - Else: fail_stage<=idx, fail_code<=01/10, init_fail pulse, init_busy<=0, go to IDLE.
- GAP: one idle cycle, then ISSUE re-pulses the same stage. The stage sees at least 2 cycles between enables.
- Abort: init_abort in ISSUE/WAIT/GAP overrides everything, including a same-cycle done. Result: fail_stage<=idx, fail_code<=11, init_fail pulse, go to IDLE. No stage_en is issued that cycle.
- init_start while busy is ignored. init_abort in IDLE is ignored.
- init_ok and init_fail are never both high. The cycle after either pulse, state is IDLE and a new start is accepted.
- Counter saturates; it does not wrap.

Decomposition:
- Package cm811_init_pkg holds the state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, GAP=3) and FAIL_NONE/ERR/TIMEOUT/ABORT codes.
- One sub-module, cm811_init_timer: clear/enable/expired timeout counter parametrised by TO_W and TIMEOUT_CYC.

Test Plan:
- Happy path, NUM_STAGES=4, each done 5 cycles after stage_en -> stage_en bits 0..3 in order, init_ok pulse once, fail_code=00, init_busy low after the pulse.
- stage_error[2] on every attempt, MAX_RETRY=2 -> stage_en[2] pulses 3 times with a GAP between each; init_fail with fail_stage=2, fail_code=01; retry_cnt=2 at the fail pulse.
- TIMEOUT_CYC=100, stage 1 silent -> timeout 100 cycles after each stage_en[1]; after 3 attempts init_fail, fail_stage=1, fail_code=10.
- Simultaneous stage_done[0] and stage_error[0] -> treated as done, sequence advances to stage 1. A stray stage_done[3] while on stage 0 is ignored.
- init_abort asserted in WAIT of stage 1, together with stage_done[1] -> init_fail next cycle, fail_code=11, fail_stage=1, no stage_en[2].
- glbl_rst_n pulsed low mid-WAIT of stage 2 -> all outputs 0 immediately (asynchronous). A new init_start after release restarts from stage 0 with fail_code cleared.
